// File: rtl/twenty_bit_subtractor_reg_if.sv
// rtl/twenty_bit_subtractor_reg_if.sv - operand/result bundle for the registered 20-bit subtractor (flags under TWENTY_BIT_SUBTRACTOR_FLAGS_EN)
interface twenty_bit_subtractor_reg_if;
   logic        in_valid;
   logic [19:0] i0;
   logic [19:0] i1;
   logic        bin;
   logic [19:0] d;
   logic        bout;
   logic        out_valid;
`ifdef TWENTY_BIT_SUBTRACTOR_FLAGS_EN
   logic        zero;
   logic        ovf;
`endif

   // operand source side
   modport master (
      output in_valid, i0, i1, bin,
`ifdef TWENTY_BIT_SUBTRACTOR_FLAGS_EN
      input  zero, ovf,
`endif
      input  d, bout, out_valid
   );

   // subtractor side
   modport slave (
      input  in_valid, i0, i1, bin,
`ifdef TWENTY_BIT_SUBTRACTOR_FLAGS_EN
      output zero, ovf,
`endif
      output d, bout, out_valid
   );
endinterface

// File: rtl/twenty_bit_subtractor_reg.sv
// rtl/twenty_bit_subtractor_reg.sv - registered 20-bit ripple-borrow subtractor d = i0 - i1 - bin (flags under TWENTY_BIT_SUBTRACTOR_FLAGS_EN)
module twenty_bit_subtractor_reg (
   input  logic                       clk,
   input  logic                       rst_n,
   twenty_bit_subtractor_reg_if.slave bus
);
   logic [19:0] diff;
   logic [20:0] br;
   logic        br_out;

   logic [19:0] d_d, d_q;
   logic        bout_d, bout_q;
   logic        out_valid_d, out_valid_q;
`ifdef TWENTY_BIT_SUBTRACTOR_FLAGS_EN
   logic        zero_d, zero_q;
   logic        ovf_d, ovf_q;
`endif

   // ripple chain of 20 one-bit full subtractors, borrow enters at bit 0
   always_comb begin
      br    = '0;
      diff  = '0;
      br[0] = bus.bin;
      for (int k = 0; k < 20; k++) begin
         diff[k]  = bus.i0[k] ^ bus.i1[k] ^ br[k];
         br[k+1]  = (~bus.i0[k] & bus.i1[k]) | (~(bus.i0[k] ^ bus.i1[k]) & br[k]);
      end
      br_out = br[20];
   end

   // capture on a valid pair, otherwise hold results; out_valid follows in_valid
   always_comb begin
      d_d         = d_q;
      bout_d      = bout_q;
      out_valid_d = bus.in_valid;
`ifdef TWENTY_BIT_SUBTRACTOR_FLAGS_EN
      zero_d      = zero_q;
      ovf_d       = ovf_q;
`endif
      if (bus.in_valid) begin
         d_d    = diff;
         bout_d = br_out;
`ifdef TWENTY_BIT_SUBTRACTOR_FLAGS_EN
         zero_d = (diff == 20'd0);
         // signed overflow: operands of opposite sign and result sign differs from minuend
         ovf_d  = (bus.i0[19] != bus.i1[19]) && (diff[19] != bus.i0[19]);
`endif
      end
   end

   // output registers, cleared immediately by reset (zero flag resets high since d = 0)
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         d_q         <= '0;
         bout_q      <= 1'b0;
         out_valid_q <= 1'b0;
`ifdef TWENTY_BIT_SUBTRACTOR_FLAGS_EN
         zero_q      <= 1'b1;
         ovf_q       <= 1'b0;
`endif
      end else begin
         d_q         <= d_d;
         bout_q      <= bout_d;
         out_valid_q <= out_valid_d;
`ifdef TWENTY_BIT_SUBTRACTOR_FLAGS_EN
         zero_q      <= zero_d;
         ovf_q       <= ovf_d;
`endif
      end
   end

   assign bus.d         = d_q;
   assign bus.bout      = bout_q;
   assign bus.out_valid = out_valid_q;
`ifdef TWENTY_BIT_SUBTRACTOR_FLAGS_EN
   assign bus.zero      = zero_q;
   assign bus.ovf       = ovf_q;
`endif
endmodule

// File: tb/tb_twenty_bit_subtractor_reg.sv
// tb/tb_twenty_bit_subtractor_reg.sv - scoreboard bench for twenty_bit_subtractor_reg (flag checks under TWENTY_BIT_SUBTRACTOR_FLAGS_EN)
module tb_twenty_bit_subtractor_reg;
   logic clk;
   logic rst_n;

   twenty_bit_subtractor_reg_if bus ();

   twenty_bit_subtractor_reg dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [19:0] d;
      logic        bout;
`ifdef TWENTY_BIT_SUBTRACTOR_FLAGS_EN
      logic        zero;
      logic        ovf;
`endif
   } exp_t;

   exp_t exp_q[$];
   exp_t held;
   int   n_checks;
   int   n_fail;

   // one comparison: count it, report on mismatch
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // 21-bit reference: {bout, d} = {0,a} - {0,b} - bi
   function automatic exp_t model(input logic [19:0] a, input logic [19:0] b, input logic bi);
      exp_t        e;
      logic [20:0] r;
      r      = {1'b0, a} - {1'b0, b} - {20'd0, bi};
      e.d    = r[19:0];
      e.bout = r[20];
`ifdef TWENTY_BIT_SUBTRACTOR_FLAGS_EN
      e.zero = (r[19:0] == 20'd0);
      e.ovf  = (a[19] != b[19]) && (r[19] != a[19]);
`endif
      return e;
   endfunction

   task automatic check_held(input string tag);
      check({tag, ".d"},    {12'd0, bus.d}, {12'd0, held.d});
      check({tag, ".bout"}, {31'd0, bus.bout}, {31'd0, held.bout});
`ifdef TWENTY_BIT_SUBTRACTOR_FLAGS_EN
      check({tag, ".zero"}, {31'd0, bus.zero}, {31'd0, held.zero});
      check({tag, ".ovf"},  {31'd0, bus.ovf},  {31'd0, held.ovf});
`endif
   endtask

   // called at a falling edge: drive a pair, then check outputs just after the next rising edge
   task automatic tick(input string tag, input logic v, input logic [19:0] a,
                       input logic [19:0] b, input logic bi);
      bus.in_valid = v;
      bus.i0       = a;
      bus.i1       = b;
      bus.bin      = bi;
      if (v) exp_q.push_back(model(a, b, bi));
      @(posedge clk);
      #1;
      check({tag, ".out_valid"}, {31'd0, bus.out_valid}, {31'd0, v});
      if (v) begin
         if (exp_q.size() == 0) begin
            check({tag, ".queue"}, 32'd0, 32'd1);
         end else begin
            held = exp_q.pop_front();
         end
      end
      check_held(tag);
      @(negedge clk);
   endtask

   initial begin
      n_checks     = 0;
      n_fail       = 0;
      held         = '0;
`ifdef TWENTY_BIT_SUBTRACTOR_FLAGS_EN
      held.zero    = 1'b1;
`endif
      rst_n        = 1'b0;
      bus.in_valid = 1'b1;
      bus.i0       = 20'h12345;
      bus.i1       = 20'h00001;
      bus.bin      = 1'b1;

      // reset held with toggling valid inputs: outputs stay at reset values
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         bus.i0  = 20'($urandom);
         bus.i1  = 20'($urandom);
         bus.bin = 1'($urandom);
         @(posedge clk);
         #1;
         check("rst.out_valid", {31'd0, bus.out_valid}, 32'd0);
         check_held("rst");
      end
      @(negedge clk);
      rst_n = 1'b1;

      // directed boundary cases
      tick("zero_zero", 1'b1, 20'd0, 20'd0, 1'b0);
      tick("wrap",      1'b1, 20'd0, 20'd1, 1'b0);
      tick("one_zero",  1'b1, 20'd1, 20'd0, 1'b0);
      tick("equal",     1'b1, 20'd110, 20'd110, 1'b0);
      tick("72_27",     1'b1, 20'd72, 20'd27, 1'b0);
      tick("72_27_b",   1'b1, 20'd72, 20'd27, 1'b1);
      tick("max_max_b", 1'b1, 20'hFFFFF, 20'hFFFFF, 1'b1);
      tick("sovf",      1'b1, 20'h80000, 20'd1, 1'b0);
      tick("hold",      1'b0, 20'h00005, 20'h00009, 1'b1);
      tick("hold2",     1'b0, 20'hABCDE, 20'h00000, 1'b0);

      // asynchronous reset in the middle of a cycle clears outputs before the next edge
      tick("pre_rst",   1'b1, 20'd500, 20'd7, 1'b0);
      bus.in_valid = 1'b1;
      bus.i0       = 20'd9;
      bus.i1       = 20'd3;
      #2;
      rst_n = 1'b0;
      #1;
      held = '0;
`ifdef TWENTY_BIT_SUBTRACTOR_FLAGS_EN
      held.zero = 1'b1;
`endif
      check("async_rst.out_valid", {31'd0, bus.out_valid}, 32'd0);
      check_held("async_rst");
      @(negedge clk);
      rst_n = 1'b1;
      tick("post_rst", 1'b1, 20'd9, 20'd3, 1'b0);

      // back-to-back random pairs, every cycle valid
      for (int i = 0; i < 150; i++) begin
         tick("rand_b2b", 1'b1, 20'($urandom), 20'($urandom), 1'($urandom));
      end

      // random pairs with gaps
      for (int i = 0; i < 60; i++) begin
         tick("rand_gap", 1'($urandom_range(0, 1)), 20'($urandom), 20'($urandom), 1'($urandom));
      end

      check("queue_empty", exp_q.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
